// File: rtl/flight_loop_sequencer.sv
// flight_loop_sequencer
// Runs one control-loop pass for each IMU sample:
//   IMU strobe -> angle_controller start -> body_frame_controller start -> motor_mixer update.
// Each wait stage has a timeout. After FAULT_LIMIT timeouts in a row the fault is latched
// and can only be cleared by reset. motor_enable keeps the motors at idle whenever the loop
// is unhealthy: IMU not in measurement mode, no completed pass for STALE_US ticks, or fault.
//
// Ports:
//   us_clk            1 MHz tick clock (the only clock)
//   resetn            asynchronous active-low reset
//   imu_good          IMU is in measurement mode
//   imu_valid_strobe  one-cycle pulse, new IMU sample ready
//   ac_complete       angle_controller completion pulse
//   bf_complete       body_frame_controller completion pulse
//   ac_start          one-cycle start pulse to angle_controller
//   bf_start          one-cycle start pulse to body_frame_controller
//   mixer_update      one-cycle pulse, motor_mixer latches new rates
//   motor_enable      pwm_generator may drive non-idle rates
//   fault             latched sequencing fault
//   seq_state         current state encoding (IDLE=0 .. FAULT=6)
//   cycle_count       completed passes, wraps
//   overrun_count     dropped strobes, saturates at 255
module flight_loop_sequencer #(
  parameter int TIMEOUT_US  = 2000,
  parameter int STALE_US    = 20000,
  parameter int FAULT_LIMIT = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   us_clk,
  input  logic                   resetn,
  input  logic                   imu_good,
  input  logic                   imu_valid_strobe,
  input  logic                   ac_complete,
  input  logic                   bf_complete,
  output logic                   ac_start,
  output logic                   bf_start,
  output logic                   mixer_update,
  output logic                   motor_enable,
  output logic                   fault,
  output logic [2:0]             seq_state,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic [7:0]             overrun_count
);

  localparam int TW = $clog2(TIMEOUT_US + 1);
  localparam int SW = $clog2(STALE_US + 1);
  localparam int FW = $clog2(FAULT_LIMIT + 1);

  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_US - 1);
  localparam logic [SW-1:0] STALE_MAX   = SW'(STALE_US);
  localparam logic [FW-1:0] FAULT_LAST  = FW'(FAULT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_AC_START = 3'd1,
    S_AC_WAIT  = 3'd2,
    S_BF_START = 3'd3,
    S_BF_WAIT  = 3'd4,
    S_MIX      = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  state_t                 state_reg, state_next;
  logic [TW-1:0]          stage_timer_reg, stage_timer_next;
  logic [SW-1:0]          stale_reg, stale_next;
  logic [FW-1:0]          timeout_cnt_reg, timeout_cnt_next;
  logic                   stage_timeout;

  logic                   ac_start_reg, ac_start_next;
  logic                   bf_start_reg, bf_start_next;
  logic                   mixer_update_reg, mixer_update_next;
  logic                   motor_enable_reg, motor_enable_next;
  logic                   fault_reg, fault_next;
  logic [COUNT_WIDTH-1:0] cycle_count_reg, cycle_count_next;
  logic [7:0]             overrun_count_reg, overrun_count_next;

  // State and output registers
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= S_IDLE;
      stage_timer_reg   <= '0;
      stale_reg         <= '0;
      timeout_cnt_reg   <= '0;
      ac_start_reg      <= 1'b0;
      bf_start_reg      <= 1'b0;
      mixer_update_reg  <= 1'b0;
      motor_enable_reg  <= 1'b0;
      fault_reg         <= 1'b0;
      cycle_count_reg   <= '0;
      overrun_count_reg <= '0;
    end else begin
      state_reg         <= state_next;
      stage_timer_reg   <= stage_timer_next;
      stale_reg         <= stale_next;
      timeout_cnt_reg   <= timeout_cnt_next;
      ac_start_reg      <= ac_start_next;
      bf_start_reg      <= bf_start_next;
      mixer_update_reg  <= mixer_update_next;
      motor_enable_reg  <= motor_enable_next;
      fault_reg         <= fault_next;
      cycle_count_reg   <= cycle_count_next;
      overrun_count_reg <= overrun_count_next;
    end
  end

  // Next-state logic, stage timer and consecutive-timeout counter
  always_comb begin
    state_next       = state_reg;
    stage_timer_next = stage_timer_reg;
    timeout_cnt_next = timeout_cnt_reg;
    stage_timeout    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (imu_valid_strobe && imu_good) state_next = S_AC_START;
      end
      S_AC_START: begin
        stage_timer_next = '0;
        state_next       = S_AC_WAIT;
      end
      S_AC_WAIT: begin
        // A completion arriving on the limit cycle takes priority over the timeout
        if (ac_complete)                         state_next = S_BF_START;
        else if (stage_timer_reg == TIMER_LIMIT) stage_timeout = 1'b1;
        else                                     stage_timer_next = stage_timer_reg + TW'(1);
      end
      S_BF_START: begin
        stage_timer_next = '0;
        state_next       = S_BF_WAIT;
      end
      S_BF_WAIT: begin
        if (bf_complete)                         state_next = S_MIX;
        else if (stage_timer_reg == TIMER_LIMIT) stage_timeout = 1'b1;
        else                                     stage_timer_next = stage_timer_reg + TW'(1);
      end
      S_MIX: begin
        timeout_cnt_next = '0;
        state_next       = S_IDLE;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase

    if (stage_timeout) begin
      timeout_cnt_next = timeout_cnt_reg + FW'(1);
      state_next       = (timeout_cnt_reg == FAULT_LAST) ? S_FAULT : S_IDLE;
    end
  end

  // Output and bookkeeping logic; everything here lands in a register next edge
  always_comb begin
    ac_start_next      = (state_next == S_AC_START);
    bf_start_next      = (state_next == S_BF_START);
    mixer_update_next  = (state_next == S_MIX);
    fault_next         = (state_next == S_FAULT);
    cycle_count_next   = cycle_count_reg;
    overrun_count_next = overrun_count_reg;

    if (state_reg == S_MIX) cycle_count_next = cycle_count_reg + COUNT_WIDTH'(1);

    // Strobes that arrive while a pass is in flight are dropped and counted
    if (imu_valid_strobe && (state_reg != S_IDLE) && (state_reg != S_FAULT) &&
        (overrun_count_reg != 8'hFF))
      overrun_count_next = overrun_count_reg + 8'd1;

    // Stale timer is zero while in MIX, so its value is the ticks since the last pass
    if (state_next == S_MIX)        stale_next = '0;
    else if (stale_reg == STALE_MAX) stale_next = stale_reg;
    else                             stale_next = stale_reg + SW'(1);

    if (fault_next || !imu_good || (stale_next == STALE_MAX)) motor_enable_next = 1'b0;
    else if (state_reg == S_MIX)                               motor_enable_next = 1'b1;
    else                                                       motor_enable_next = motor_enable_reg;
  end

  assign ac_start      = ac_start_reg;
  assign bf_start      = bf_start_reg;
  assign mixer_update  = mixer_update_reg;
  assign motor_enable  = motor_enable_reg;
  assign fault         = fault_reg;
  assign seq_state     = state_reg;
  assign cycle_count   = cycle_count_reg;
  assign overrun_count = overrun_count_reg;

endmodule

// File: tb/tb_flight_loop_sequencer.sv
// Testbench for flight_loop_sequencer. Pulse outputs are checked through a scoreboard:
// each expected pulse (kind + cycle) is queued when stimulus is driven and popped when
// the DUT emits a pulse. Level outputs are checked directly at points in the sequence.
module tb_flight_loop_sequencer;

  localparam int TIMEOUT_US  = 8;
  localparam int STALE_US    = 50;
  localparam int FAULT_LIMIT = 3;
  localparam int COUNT_WIDTH = 16;

  localparam int EV_AC  = 1;
  localparam int EV_BF  = 2;
  localparam int EV_MIX = 3;

  logic                   us_clk = 1'b0;
  logic                   resetn;
  logic                   imu_good;
  logic                   imu_valid_strobe;
  logic                   ac_complete;
  logic                   bf_complete;
  logic                   ac_start;
  logic                   bf_start;
  logic                   mixer_update;
  logic                   motor_enable;
  logic                   fault;
  logic [2:0]             seq_state;
  logic [COUNT_WIDTH-1:0] cycle_count;
  logic [7:0]             overrun_count;

  flight_loop_sequencer #(
    .TIMEOUT_US (TIMEOUT_US),
    .STALE_US   (STALE_US),
    .FAULT_LIMIT(FAULT_LIMIT),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .us_clk          (us_clk),
    .resetn          (resetn),
    .imu_good        (imu_good),
    .imu_valid_strobe(imu_valid_strobe),
    .ac_complete     (ac_complete),
    .bf_complete     (bf_complete),
    .ac_start        (ac_start),
    .bf_start        (bf_start),
    .mixer_update    (mixer_update),
    .motor_enable    (motor_enable),
    .fault           (fault),
    .seq_state       (seq_state),
    .cycle_count     (cycle_count),
    .overrun_count   (overrun_count)
  );

  always #5 us_clk = ~us_clk;

  int cyc = 0;
  always @(posedge us_clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  tests_run    = 0;
  int  tests_failed = 0;
  int  exp_cycles   = 0;
  int  exp_ovr      = 0;
  int  last_mix     = 0;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic note_pulse(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_value("unexpected_pulse", kind, 0);
    end else begin
      e = exp_q.pop_front();
      check_value("pulse_kind", kind, e.kind);
      check_value("pulse_cycle", cyc, e.cyc);
      $display("[TB] cycle %0d pulse kind %0d (expected kind %0d at %0d)", cyc, kind, e.kind, e.cyc);
    end
  endtask

  // Pulse monitor, sampled on the falling edge
  always @(negedge us_clk) begin
    if (ac_start)     note_pulse(EV_AC);
    if (bf_start)     note_pulse(EV_BF);
    if (mixer_update) note_pulse(EV_MIX);
  end

  task automatic tick();
    @(posedge us_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_ac_start"},      ac_start, 0);
    check_value({tag, "_bf_start"},      bf_start, 0);
    check_value({tag, "_mixer_update"},  mixer_update, 0);
    check_value({tag, "_motor_enable"},  motor_enable, 0);
    check_value({tag, "_fault"},         fault, 0);
    check_value({tag, "_seq_state"},     seq_state, 0);
    check_value({tag, "_cycle_count"},   cycle_count, 0);
    check_value({tag, "_overrun_count"}, overrun_count, 0);
  endtask

  // One full pass. Strobe at offset 0, ac_complete at offset a, bf_complete at offset b
  // (both relative to the strobe cycle). ovr drives extra strobes through BF_WAIT.
  // drop_at > 0 drops imu_good at that offset and checks motor_enable one cycle later.
  task automatic run_pass(input int a, input int b, input bit ovr, input int drop_at);
    int t0;
    t0 = cyc;
    push_ev(EV_AC, t0 + 1);
    push_ev(EV_BF, t0 + a + 1);
    push_ev(EV_MIX, t0 + b + 1);
    for (int k = 0; k <= b + 1; k++) begin
      imu_valid_strobe = (k == 0) || (ovr && k >= a + 2 && k <= b);
      if (k > 0 && imu_valid_strobe && exp_ovr < 255) exp_ovr++;
      ac_complete = (k == a);
      bf_complete = (k == b);
      if (drop_at > 0 && k == drop_at) imu_good = 1'b0;
      if (drop_at > 0 && k == drop_at + 1) check_value("imu_loss_enable", motor_enable, 0);
      tick();
    end
    imu_valid_strobe = 1'b0;
    ac_complete      = 1'b0;
    bf_complete      = 1'b0;
    exp_cycles++;
    last_mix = t0 + b + 1;
    $display("[TB] pass a=%0d b=%0d ovr=%0d done at cycle %0d, cycle_count=%0d overrun=%0d",
             a, b, ovr, cyc, cycle_count, overrun_count);
  endtask

  // Strobe with no ac_complete; AC_WAIT lasts TIMEOUT_US cycles
  task automatic timeout_run(input int exp_state, input int exp_fault);
    int t0;
    t0 = cyc;
    push_ev(EV_AC, t0 + 1);
    imu_valid_strobe = 1'b1;
    tick();
    imu_valid_strobe = 1'b0;
    while (cyc < t0 + 1 + TIMEOUT_US) tick();
    check_value("timeout_wait_state", seq_state, 2);
    tick();
    check_value("timeout_state", seq_state, exp_state);
    check_value("timeout_fault", fault, exp_fault);
    $display("[TB] timeout run at cycle %0d: state=%0d fault=%0d", cyc, seq_state, fault);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    imu_good = 1'b0;
    imu_valid_strobe = 1'b0;
    ac_complete = 1'b0;
    bf_complete = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    resetn = 1'b1;
    imu_good = 1'b1;
    tick();

    // Stray completes in IDLE do nothing
    ac_complete = 1'b1;
    bf_complete = 1'b1;
    tick();
    ac_complete = 1'b0;
    bf_complete = 1'b0;
    tick();
    check_value("stray_idle_state", seq_state, 0);

    // Normal pass: ac at t0+5, bf at t0+9
    check_value("pre_pass_enable", motor_enable, 0);
    run_pass(5, 9, 1'b0, 0);
    check_value("normal_cycle_count", cycle_count, exp_cycles);
    check_value("normal_enable", motor_enable, 1);
    check_value("normal_state", seq_state, 0);

    // Completions on the exact timeout-limit cycle of both wait stages
    run_pass(TIMEOUT_US + 1, 2 * TIMEOUT_US + 2, 1'b0, 0);
    check_value("tie_cycle_count", cycle_count, exp_cycles);

    // Stale: enable falls STALE_US cycles after MIX
    while (cyc < last_mix + STALE_US - 1) tick();
    check_value("stale_before", motor_enable, 1);
    tick();
    check_value("stale_after", motor_enable, 0);

    // Re-enable, then lose the IMU in BF_WAIT
    run_pass(2, 4, 1'b0, 0);
    check_value("reenable", motor_enable, 1);
    run_pass(3, 10, 1'b0, 7);
    check_value("imu_loss_after_mix", motor_enable, 0);
    check_value("imu_loss_cycle_count", cycle_count, exp_cycles);
    imu_valid_strobe = 1'b1;
    tick();
    imu_valid_strobe = 1'b0;
    tick();
    check_value("imu_bad_strobe_state", seq_state, 0);
    check_value("imu_bad_strobe_ovr", overrun_count, exp_ovr);
    imu_good = 1'b1;
    tick();

    // Overrun: 7 strobes per pass in BF_WAIT, 43 passes
    run_pass(2, 10, 1'b1, 0);
    check_value("overrun_first", overrun_count, exp_ovr);
    for (int p = 0; p < 42; p++) run_pass(2, 10, 1'b1, 0);
    check_value("overrun_sat", overrun_count, 255);
    check_value("overrun_model", overrun_count, exp_ovr);
    check_value("overrun_cycle_count", cycle_count, exp_cycles);
    check_value("overrun_enable", motor_enable, 1);

    // Consecutive timeouts lead to the latched fault
    timeout_run(0, 0);
    timeout_run(0, 0);
    timeout_run(6, 1);
    check_value("fault_enable", motor_enable, 0);
    for (int i = 0; i < 3; i++) begin
      imu_valid_strobe = 1'b1;
      tick();
      imu_valid_strobe = 1'b0;
      repeat (3) tick();
    end
    check_value("fault_hold_state", seq_state, 6);
    check_value("fault_hold_fault", fault, 1);
    check_value("fault_cycle_count", cycle_count, exp_cycles);

    // Reset clears the fault
    resetn = 1'b0;
    #1;
    check_all_zero("reset_fault");
    tick();
    resetn = 1'b1;
    tick();

    // Reset during AC_WAIT aborts the pass; a late ac_complete is ignored
    push_ev(EV_AC, cyc + 1);
    imu_valid_strobe = 1'b1;
    tick();
    imu_valid_strobe = 1'b0;
    tick();
    tick();
    check_value("mid_pass_state", seq_state, 2);
    resetn = 1'b0;
    #1;
    check_all_zero("reset_mid");
    tick();
    tick();
    resetn = 1'b1;
    tick();
    ac_complete = 1'b1;
    tick();
    ac_complete = 1'b0;
    repeat (3) tick();
    check_value("after_reset_state", seq_state, 0);
    check_value("after_reset_count", cycle_count, 0);

    check_value("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/flight_loop_sequencer.md
Name: flight_loop_sequencer

Overview:
- Sequences one control-loop pass per IMU sample: IMU valid strobe -> angle_controller start -> body_frame_controller start -> motor_mixer update.
- Replaces the tied-off start_signal and open strobe chaining in drone2 with a controlled handshake.
- Bounds every stage with a timeout and latches a fault after repeated timeouts.
- Gates motor output through motor_enable when the loop is unhealthy.

Parameters:
- TIMEOUT_US, 2000: us_clk cycles allowed in each wait state before a timeout.
- STALE_US, 20000: us_clk cycles since the last completed pass before motor_enable drops.
- FAULT_LIMIT, 3: consecutive timeouts that cause the latched fault.
- COUNT_WIDTH, 16: width of cycle_count.

Ports:
- us_clk  in  1  1 MHz system tick clock; the only clock.
- resetn  in  1  asynchronous active-low reset.
- imu_good  in  1  IMU is in measurement mode.
- imu_valid_strobe  in  1  one-cycle pulse; a new IMU sample is ready.
- ac_complete  in  1  angle_controller complete_signal pulse.
- bf_complete  in  1  body_frame_controller complete_signal pulse.
- ac_start  out  1  one-cycle start pulse to angle_controller.
- bf_start  out  1  one-cycle start pulse to body_frame_controller.
- mixer_update  out  1  one-cycle pulse; motor_mixer latches new rates.
- motor_enable  out  1  high when pwm_generator may drive non-idle rates.
- fault  out  1  latched sequencing fault.
- seq_state  out  3  current state encoding.
- cycle_count  out  COUNT_WIDTH  completed passes; wraps.
- overrun_count  out  8  saturating count of dropped strobes.

Behaviour:
- Clock and reset:
  - Single clock us_clk; reset is asynchronous and active-low on resetn.
  - While resetn=0, all outputs are 0 and seq_state=IDLE.
  - Reset asserted mid-pass aborts the pass immediately; no start or update pulse is emitted afterwards.
- States: IDLE=0, AC_START=1, AC_WAIT=2, BF_START=3, BF_WAIT=4, MIX=5, FAULT=6. All outputs are registered.
- IDLE: imu_valid_strobe=1 and imu_good=1 -> AC_START. A strobe with imu_good=0 is ignored and is not counted as an overrun.
- AC_START: ac_start=1 for exactly this cycle. The stage timer clears. Next state is AC_WAIT.
- AC_WAIT:
  - ac_complete=1 -> BF_START.
  - Otherwise the timer increments; when it reaches TIMEOUT_US-1 -> timeout.
- BF_START: bf_start=1 for one cycle. The timer clears. Next state is BF_WAIT.
- BF_WAIT: same rules as AC_WAIT, using bf_complete.
- MIX:
  - mixer_update=1 for one cycle.
  - cycle_count increments, wrapping at 2^COUNT_WIDTH.
  - The consecutive-timeout counter clears and the stale timer clears.
  - Next state is IDLE.
- Latency:
  - Strobe in IDLE at cycle n -> ac_start at n+1.
  - ac_complete at cycle m (m >= n+2) -> bf_start at m+1.
  - bf_complete at cycle k -> mixer_update at k+1.
  - Minimum pass: 6 cycles from strobe to return to IDLE.
- Timeout:
  - Return to IDLE with no mixer_update; the consecutive-timeout counter increments.
  - When the counter reaches FAULT_LIMIT -> FAULT.
  - A complete pulse in the same cycle as the timeout limit wins: the stage succeeds.
- FAULT: fault=1, motor_enable=0. No start pulses are issued. Exit only by reset.
- Stray inputs:
  - ac_complete or bf_complete outside its own wait state is ignored.
  - bf_complete in AC_WAIT does not advance the sequence.
- Overrun: imu_valid_strobe in any state other than IDLE or FAULT is dropped, and overrun_count increments, saturating at 255.
- Stale timer:
  - Counts up every cycle and saturates at STALE_US.
  - Clears in MIX.
- motor_enable:
  - Goes to 1 on the cycle after MIX when imu_good=1 and fault=0.
  - Goes to 0 the cycle after any of: imu_good=0, stale timer reaches STALE_US, or fault.
  - Stays 0 until the next successful MIX with imu_good=1.
- Timer widths: each timer is at least clog2(parameter+1) bits. No timer wraps.

Test Plan:
- Normal pass:
  - Stimulus: reset, imu_good=1; strobe at t0; ac_complete at t0+5; bf_complete at t0+9.
  - Required: ac_start at t0+1, bf_start at t0+6, mixer_update at t0+10, cycle_count=1, motor_enable=1 at t0+11.
- Timeout:
  - Stimulus: TIMEOUT_US=8; strobe; no ac_complete.
  - Required: return to IDLE after 8 cycles in AC_WAIT, no bf_start or mixer_update, fault=0.
  - Repeat until 3 consecutive timeouts -> fault=1, seq_state=6, motor_enable=0; further strobes produce no ac_start.
- Tie-break:
  - Stimulus: ac_complete in the exact cycle the timer hits the limit.
  - Required: bf_start is issued; the timeout counter is unchanged.
- Overrun:
  - Stimulus: 300 strobes delivered while in BF_WAIT.
  - Required: overrun_count=255; the pass still completes normally.
- Stale and IMU loss:
  - Stimulus: STALE_US=50; one good pass, then no strobes.
  - Required: motor_enable falls 50 cycles after MIX.
  - Stimulus: imu_good dropped mid-BF_WAIT.
  - Required: motor_enable=0 next cycle; the strobe is ignored while imu_good=0.
- Reset mid-pass:
  - Stimulus: resetn low during AC_WAIT, then a late ac_complete after reset is released.
  - Required: all outputs 0, seq_state=0, and no bf_start is produced.
